// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg: opcode map, instruction-field offsets and fault-bit indices
// shared by the mini_alu_core datapath, its return stack and its benches.
package mini_alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_STO  = 4'd3;
  localparam logic [3:0] OP_BLE  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_CALL = 4'd6;
  localparam logic [3:0] OP_RET  = 4'd7;
  localparam logic [3:0] OP_LED  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_OUT  = 4'd10;
  localparam logic [3:0] OP_RSVD = 4'd11;

  localparam int FAULT_OVF = 0;  // CALL with a full return stack
  localparam int FAULT_UNF = 1;  // RET with an empty return stack

  // Instruction layout: {op[3:0], dst, src1, src0}, src0 at bit 0.
  function automatic int src1_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int dst_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int op_lsb(input int addr_w);
    return 3 * addr_w;
  endfunction

  function automatic int instr_w(input int addr_w);
    return 4 + 3 * addr_w;
  endfunction

endpackage

// File: rtl/mini_alu_core_if.sv
// mini_alu_core_if: instruction-fetch, LED and peripheral-output signals of
// mini_alu_core. The core drives the master side; ROM/peripherals the slave.
interface mini_alu_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8
);

  logic [IP_W-1:0]       oIP;
  logic [4+3*ADDR_W-1:0] iInstruction;
  logic [LED_W-1:0]      oLed;
  logic                  oOutValid;
  logic [DATA_W-1:0]     oOutData;
  logic                  iOutReady;
  logic [1:0]            oFault;

  modport master (
    output oIP, oLed, oOutValid, oOutData, oFault,
    input  iInstruction, iOutReady
  );

  modport slave (
    input  oIP, oLed, oOutValid, oOutData, oFault,
    output iInstruction, iOutReady
  );

endinterface

// File: rtl/mini_alu_return_stack.sv
// mini_alu_return_stack: LIFO of return addresses for CALL/RET. Pushes while
// full and pops while empty are ignored; the core turns them into faults.
module mini_alu_return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int SP_W = $clog2(DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_ONE  = 1;
  localparam logic [SP_W-2:0] IDX_ONE = 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-2:0] top_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[SP_W-2:0] - IDX_ONE;
  assign top     = mem[top_idx];

  // Stack pointer: counts live entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_ONE;
    end else if (pop && !empty) begin
      sp <= sp - SP_ONE;
    end
  end

  // Entry storage: written at the slot the pointer currently addresses.
  // NOTE: storage arrays are left unreset; the pointer alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[SP_W-2:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage fetch/execute core with internal register file,
// return stack, LED latch and a valid/ready OUT port.
// Build option: define MINI_ALU_MUL_EN to give MUL a single-cycle
// DATA_W x DATA_W multiplier; otherwise MUL executes as NOP.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 8,
  parameter int LED_W       = 8
) (
  input logic               Clock,
  input logic               Reset,
  mini_alu_core_if.master   bus
);

  localparam int INSTR_W  = instr_w(ADDR_W);
  localparam int OP_LSB   = op_lsb(ADDR_W);
  localparam int DST_LSB  = dst_lsb(ADDR_W);
  localparam int SRC1_LSB = src1_lsb(ADDR_W);
  localparam logic [IP_W-1:0] IP_ONE = 1;

  logic [INSTR_W-1:0] ir;
  logic [IP_W-1:0]    pc;
  logic [IP_W-1:0]    fetch_ip;
  logic [DATA_W-1:0]  rf [2**ADDR_W];

  logic [3:0]        op;
  logic [ADDR_W-1:0] dst, src1, src0;
  logic [DATA_W-1:0] r1, r0, imm;

  logic              taken, push, pop, set_ovf, set_unf, wr_en;
  logic [IP_W-1:0]   target;
  logic [DATA_W-1:0] wr_data;
  logic              st_full, st_empty;
  logic [IP_W-1:0]   st_top;

  logic [LED_W-1:0]  led_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [1:0]        fault_q;
  logic              out_launch, out_done, stall;

  assign op   = ir[OP_LSB +: 4];
  assign dst  = ir[DST_LSB +: ADDR_W];
  assign src1 = ir[SRC1_LSB +: ADDR_W];
  assign src0 = ir[0 +: ADDR_W];
  assign r1   = rf[src1];
  assign r0   = rf[src0];
  assign imm  = DATA_W'({src1, src0});

`ifdef MINI_ALU_MUL_EN
  logic [2*DATA_W-1:0] product;
  assign product = r1 * r0;
`endif

  // An OUT sits in IR for at least two cycles: one to launch, then until accepted.
  assign out_launch = (op == OP_OUT) && !out_valid_q;
  assign out_done   = out_valid_q && bus.iOutReady;
  assign stall      = (op == OP_OUT) && !out_done;

  // Execute decode: branch resolution, stack control and write-back data.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    taken   = 1'b0;
    target  = IP_W'(dst);
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (op)
      OP_ADD: begin wr_en = 1'b1; wr_data = r1 + r0; end
      OP_SUB: begin wr_en = 1'b1; wr_data = r1 - r0; end
      OP_STO: begin wr_en = 1'b1; wr_data = imm; end
      OP_BLE: taken = (r1 <= r0);
      OP_JMP: taken = 1'b1;
      OP_CALL: begin
        if (!st_full) begin
          push  = 1'b1;
          taken = 1'b1;
        end else begin
          set_ovf = 1'b1;
        end
      end
      OP_RET: begin
        if (!st_empty) begin
          pop    = 1'b1;
          taken  = 1'b1;
          target = st_top;
        end else begin
          set_unf = 1'b1;
        end
      end
`ifdef MINI_ALU_MUL_EN
      OP_MUL: begin wr_en = 1'b1; wr_data = product[DATA_W-1:0]; end
`endif
      default: ;
    endcase
  end

  // Zero-bubble branches: the target is fetched while the branch executes.
  assign fetch_ip = taken ? target : pc;

  // Fetch stage: hold PC and IR while an OUT is outstanding.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc <= '0;
      ir <= '0;
    end else if (!stall) begin
      pc <= fetch_ip + IP_ONE;
      ir <= bus.iInstruction;
    end
  end

  // Register-file write-back, visible to the next instruction.
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      rf[dst] <= wr_data;
    end
  end

  // LED latch, sticky faults and OUT handshake registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      led_q       <= '0;
      fault_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (op == OP_LED) begin
        led_q <= r1[LED_W-1:0];
      end
      fault_q[FAULT_OVF] <= fault_q[FAULT_OVF] | set_ovf;
      fault_q[FAULT_UNF] <= fault_q[FAULT_UNF] | set_unf;
      if (out_launch) begin
        out_valid_q <= 1'b1;
        out_data_q  <= imm;
      end else if (out_done) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  mini_alu_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (IP_W)
  ) u_stack (
    .clk       (Clock),
    .rst_n     (Reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .full      (st_full),
    .empty     (st_empty),
    .top       (st_top)
  );

  assign bus.oIP       = fetch_ip;
  assign bus.oLed      = led_q;
  assign bus.oOutValid = out_valid_q;
  assign bus.oOutData  = out_data_q;
  assign bus.oFault    = fault_q;

endmodule

// File: tb/tb_mini_alu_core.sv
// tb_mini_alu_core: directed programs in a bench-side ROM, with hand-computed
// expectations checked after each clock edge.
module tb_mini_alu_core;
  import mini_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [27:0] rom [256];
  int vectors = 0;
  int miscompares = 0;

  mini_alu_core_if bus ();

  mini_alu_core dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.iInstruction = rom[bus.oIP[7:0]];

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {OP_STO, d, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  // Hold reset over two edges, release mid-cycle; next posedge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bus.iOutReady = 1'b0;

    // ALU and LED: 5-3=2, then 3-5=FFFE.
    clear_rom();
    rom[0] = sto(8'd1, 16'd5);
    rom[1] = sto(8'd2, 16'd3);
    rom[2] = ins(OP_SUB, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[4] = ins(OP_SUB, 8'd4, 8'd2, 8'd1);
    rom[5] = ins(OP_LED, 8'd0, 8'd4, 8'd0);
    rom[6] = ins(OP_JMP, 8'h06, 8'd0, 8'd0);
    do_reset();
    check("rst_ip", bus.oIP, 0);
    check("rst_led", bus.oLed, 0);
    check("rst_valid", bus.oOutValid, 0);
    check("rst_data", bus.oOutData, 0);
    check("rst_fault", bus.oFault, 0);
    repeat (4) step();
    check("led_before", bus.oLed, 0);
    step();
    check("led_5minus3", bus.oLed, 8'h02);
    step();
    check("rf_3minus5", dut.rf[4], 16'hFFFE);
    step();
    check("led_3minus5", bus.oLed, 8'hFE);
    check("jmp_ip", bus.oIP, 16'h0006);

    // BLE: equal operands taken, greater not taken, smaller taken.
    clear_rom();
    rom[0] = sto(8'd5, 16'd4);
    rom[1] = sto(8'd6, 16'd4);
    rom[2] = sto(8'd7, 16'd5);
    rom[3] = ins(OP_BLE, 8'h10, 8'd5, 8'd6);
    rom[8'h10] = ins(OP_BLE, 8'h30, 8'd7, 8'd5);
    rom[8'h11] = ins(OP_BLE, 8'h60, 8'd5, 8'd7);
    do_reset();
    repeat (4) step();
    check("ble_eq_taken", bus.oIP, 16'h0010);
    step();
    check("ble_gt_seq", bus.oIP, 16'h0011);
    step();
    check("ble_lt_taken", bus.oIP, 16'h0060);

    // CALL/RET and return-stack overflow.
    clear_rom();
    rom[0] = ins(OP_CALL, 8'h20, 8'd0, 8'd0);
    rom[8'h20] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[1] = ins(OP_CALL, 8'h50, 8'd0, 8'd0);
    for (int i = 0; i < 7; i++) rom[8'h50 + i] = ins(OP_CALL, 8'(8'h51 + i), 8'd0, 8'd0);
    rom[8'h57] = ins(OP_CALL, 8'h90, 8'd0, 8'd0);
    rom[8'h58] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    do_reset();
    step();
    check("call_target", bus.oIP, 16'h0020);
    step();
    check("ret_target", bus.oIP, 16'h0001);
    step();
    check("call2_target", bus.oIP, 16'h0050);
    repeat (8) step();
    check("call9_not_taken", bus.oIP, 16'h0058);
    check("fault_before_ovf", bus.oFault, 2'b00);
    step();
    check("fault_ovf", bus.oFault, 2'b01);
    check("ret_lifo", bus.oIP, 16'h0057);
    step();
    check("call_after_pop", bus.oIP, 16'h0090);

    // OUT with four not-ready cycles.
    clear_rom();
    rom[0] = ins(OP_OUT, 8'd0, 8'h00, 8'h41);
    rom[1] = ins(OP_JMP, 8'h33, 8'd0, 8'd0);
    do_reset();
    step();
    check("out_first_valid", bus.oOutValid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("out_wait_valid", bus.oOutValid, 1);
      check("out_wait_ip", bus.oIP, 16'h0001);
      check("out_wait_data", bus.oOutData, 16'h0041);
    end
    bus.iOutReady = 1'b1;
    step();
    bus.iOutReady = 1'b0;
    check("out_done_valid", bus.oOutValid, 0);
    check("out_done_ip", bus.oIP, 16'h0033);

    // Asynchronous reset during an OUT stall, after an underflow and a LED write.
    clear_rom();
    rom[0] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[1] = sto(8'd10, 16'h0077);
    rom[2] = ins(OP_LED, 8'd0, 8'd10, 8'd0);
    rom[3] = ins(OP_OUT, 8'd0, 8'h00, 8'h41);
    rom[4] = ins(OP_JMP, 8'h04, 8'd0, 8'd0);
    do_reset();
    step();
    check("ret_empty_seq", bus.oIP, 16'h0001);
    step();
    check("fault_unf", bus.oFault, 2'b10);
    repeat (4) step();
    check("pre_rst_led", bus.oLed, 8'h77);
    check("pre_rst_valid", bus.oOutValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", bus.oOutValid, 0);
    check("async_ip", bus.oIP, 0);
    check("async_led", bus.oLed, 0);
    check("async_fault", bus.oFault, 0);
    check("async_data", bus.oOutData, 0);

    // MUL (build-dependent) and a reserved opcode that must not write.
    clear_rom();
    rom[0] = sto(8'd11, 16'h0100);
    rom[1] = sto(8'd12, 16'h0100);
    rom[2] = sto(8'd13, 16'h1234);
    rom[3] = sto(8'd14, 16'hABCD);
    rom[4] = sto(8'd15, 16'h0003);
    rom[5] = ins(OP_MUL, 8'd13, 8'd11, 8'd12);
    rom[6] = ins(OP_MUL, 8'd14, 8'd12, 8'd15);
    rom[7] = ins(OP_RSVD, 8'd14, 8'h00, 8'h55);
    rom[8] = ins(OP_JMP, 8'h08, 8'd0, 8'd0);
    do_reset();
    repeat (8) step();
`ifdef MINI_ALU_MUL_EN
    check("mul_wrap", dut.rf[13], 16'h0000);
    check("mul_small", dut.rf[14], 16'h0300);
    step();
    check("rsvd_nop", dut.rf[14], 16'h0300);
`else
    check("mul_off_r13", dut.rf[13], 16'h1234);
    check("mul_off_r14", dut.rf[14], 16'hABCD);
    step();
    check("rsvd_nop", dut.rf[14], 16'hABCD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
